// File: rtl/lc3_pkg.sv
// lc3_pkg: shared types and encodings for the LC-3 control FSM.
// State enum, opcode constants, mux/ALU select encodings and the
// control-word struct passed from the decoder to the FSM top.
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALT   = 5'd0,
        S_FETCH1 = 5'd1,
        S_FETCH2 = 5'd2,
        S_FETCH3 = 5'd3,
        S_DECODE = 5'd4,
        S_ADD    = 5'd5,
        S_AND    = 5'd6,
        S_NOT    = 5'd7,
        S_BR0    = 5'd8,
        S_BR1    = 5'd9,
        S_JMP    = 5'd10,
        S_LDR1   = 5'd11,
        S_LDR2   = 5'd12,
        S_LDR3   = 5'd13,
        S_STR1   = 5'd14,
        S_STR2   = 5'd15,
        S_STR3   = 5'd16,
        S_PAUSE  = 5'd17
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic       ADDR1_PC  = 1'b0;
    localparam logic       ADDR1_SR1 = 1'b1;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

endpackage

// File: rtl/lc3_ctrl_decode.sv
// lc3_ctrl_decode: combinational Moore decode of FSM state into the
// control word. wait_last marks the final cycle of a memory access so
// the read data is latched into MDR only once it is valid.
module lc3_ctrl_decode
    import lc3_pkg::*;
(
    input  state_t state,
    input  logic   wait_last,
    output ctrl_t  ctrl
);

    // Every field defaults to 0; each state raises only its own strobes.
    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH1: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.ld_pc   = 1'b1;
                ctrl.pcmux   = PCMUX_PC1;
            end
            S_FETCH2, S_LDR2: begin
                ctrl.mem_oe = 1'b1;
                ctrl.ld_mdr = wait_last;
            end
            S_FETCH3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_DECODE: ctrl.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl.gate_alu = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.aluk     = (state == S_ADD) ? ALUK_ADD :
                                (state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR1: begin
                ctrl.addr1mux = ADDR1_PC;
                ctrl.addr2mux = ADDR2_OFF9;
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl.addr1mux = ADDR1_SR1;
                ctrl.addr2mux = ADDR2_ZERO;
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl.addr1mux    = ADDR1_SR1;
                ctrl.addr2mux    = ADDR2_OFF6;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_STR2: begin
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_STR3: ctrl.mem_we = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// lc3_ctrl_fsm: LC-3 subset control sequencer (fetch/decode/execute).
// Optional build macro LC3_PAUSE_EN adds a PAUSE state entered on
// opcode 1101 and left on Continue; without it 1101 is unsupported.
//
// state  | meaning
// HALT   | idle, waits for Run
// FETCH1 | MAR <- PC, PC <- PC+1
// FETCH2 | instruction read, held MEM_WAIT cycles
// FETCH3 | IR <- MDR
// DECODE | BEN latched, dispatch on IR[15:12]
// ADD    | ALU add, write back, set CC
// AND    | ALU and, write back, set CC
// NOT    | ALU not, write back, set CC
// BR0    | test BEN
// BR1    | PC <- PC + off9
// JMP    | PC <- SR1
// LDR1   | MAR <- SR1 + off6
// LDR2   | data read, held MEM_WAIT cycles
// LDR3   | DR <- MDR, set CC
// STR1   | MAR <- SR1 + off6
// STR2   | MDR <- SR (ALU pass A)
// STR3   | data write, held MEM_WAIT cycles
// PAUSE  | stalled until Continue (LC3_PAUSE_EN only)
module lc3_ctrl_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 3      // memory state hold cycles, 1..15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [4:0]  state_dbg
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       wait_last;
    ctrl_t      ctrl;
    logic       unused_inputs;

    assign wait_last = (wait_cnt == WAIT_LAST);

    function automatic state_t dispatch(input logic [3:0] op);
        state_t nxt;
        nxt = S_FETCH1;
        unique case (op)
            OP_ADD:   nxt = S_ADD;
            OP_AND:   nxt = S_AND;
            OP_NOT:   nxt = S_NOT;
            OP_BR:    nxt = S_BR0;
            OP_JMP:   nxt = S_JMP;
            OP_LDR:   nxt = S_LDR1;
            OP_STR:   nxt = S_STR1;
`ifdef LC3_PAUSE_EN
            OP_PAUSE: nxt = S_PAUSE;
`endif
            default:  nxt = S_FETCH1;
        endcase
        return nxt;
    endfunction

    // State register and wait counter; the counter idles at zero so it is
    // already clear on entry to any memory state, and counts only while held.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= S_HALT;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                S_HALT:   if (Run) state <= S_FETCH1;
                S_FETCH1: state <= S_FETCH2;
                S_FETCH2: begin
                    if (wait_last) state <= S_FETCH3;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
                S_FETCH3: state <= S_DECODE;
                S_DECODE: state <= dispatch(IR[15:12]);
                S_ADD, S_AND, S_NOT, S_BR1, S_JMP, S_LDR3:
                          state <= S_FETCH1;
                S_BR0:    state <= BEN ? S_BR1 : S_FETCH1;
                S_LDR1:   state <= S_LDR2;
                S_LDR2: begin
                    if (wait_last) state <= S_LDR3;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
                S_STR1:   state <= S_STR2;
                S_STR2:   state <= S_STR3;
                S_STR3: begin
                    if (wait_last) state <= S_FETCH1;
                    else           wait_cnt <= wait_cnt + 4'd1;
                end
`ifdef LC3_PAUSE_EN
                S_PAUSE:  if (Continue) state <= S_FETCH1;
`endif
                default:  state <= S_HALT;
            endcase
        end
    end

    lc3_ctrl_decode u_decode (
        .state     (state),
        .wait_last (wait_last),
        .ctrl      (ctrl)
    );

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_PC      = ctrl.ld_pc;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign PCMUX      = ctrl.pcmux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign ALUK       = ctrl.aluk;
    assign Mem_OE     = ctrl.mem_oe;
    assign Mem_WE     = ctrl.mem_we;
    assign state_dbg  = state;

    // Operand fields of IR belong to the datapath, not the sequencer.
`ifdef LC3_PAUSE_EN
    assign unused_inputs = ^IR[11:0];
`else
    assign unused_inputs = ^{IR[11:0], Continue};
`endif

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// tb_lc3_ctrl_fsm: scoreboard bench for lc3_ctrl_fsm. Stimulus pushes the
// expected per-cycle state/control trace of each directed instruction;
// a negedge monitor pops and compares against the DUT outputs.
module tb_lc3_ctrl_fsm;
    import lc3_pkg::*;

    localparam int MW = 3;

    logic        Clk = 1'b0;
    logic        Reset_n, Run, Continue, BEN;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, Mem_OE, Mem_WE;
    logic [4:0]  state_dbg;
    logic [19:0] act_ctl;

    typedef struct packed {
        logic [4:0]  st;
        logic [19:0] ctl;
    } rec_t;

    rec_t sb[$];
    rec_t mon_rec;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;

    always #5 Clk = ~Clk;

    lc3_ctrl_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .state_dbg(state_dbg)
    );

    assign act_ctl = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                      GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR1MUX,
                      ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    // Hand-written control table for each state.
    function automatic logic [19:0] exp_ctl(input state_t s, input logic last);
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic g_pc, g_mdr, g_alu, g_mm, a1, oe, we;
        logic [1:0] pcm, a2, aluk;
        {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc} = '0;
        {g_pc, g_mdr, g_alu, g_mm, a1, oe, we} = '0;
        pcm = 2'b00; a2 = 2'b00; aluk = 2'b00;
        case (s)
            S_FETCH1: begin g_pc = 1; ld_mar = 1; ld_pc = 1; end
            S_FETCH2: begin oe = 1; ld_mdr = last; end
            S_FETCH3: begin g_mdr = 1; ld_ir = 1; end
            S_DECODE: ld_ben = 1;
            S_ADD:    begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b00; end
            S_AND:    begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b01; end
            S_NOT:    begin g_alu = 1; ld_reg = 1; ld_cc = 1; aluk = 2'b10; end
            S_BR1:    begin a1 = 0; a2 = 2'b10; pcm = 2'b10; ld_pc = 1; end
            S_JMP:    begin a1 = 1; a2 = 2'b00; pcm = 2'b10; ld_pc = 1; end
            S_LDR1, S_STR1: begin a1 = 1; a2 = 2'b01; g_mm = 1; ld_mar = 1; end
            S_LDR2:   begin oe = 1; ld_mdr = last; end
            S_LDR3:   begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
            S_STR2:   begin aluk = 2'b11; g_alu = 1; ld_mdr = 1; end
            S_STR3:   we = 1;
            default:  ;
        endcase
        return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc,
                g_pc, g_mdr, g_alu, g_mm, pcm, a1, a2, aluk, oe, we};
    endfunction

    task automatic push(input state_t s, input logic last);
        rec_t r;
        r.st  = s;
        r.ctl = exp_ctl(s, last);
        sb.push_back(r);
        pushed++;
    endtask

    task automatic push_mem(input state_t s);
        for (int i = 0; i < MW; i++) push(s, i == MW - 1);
    endtask

    task automatic push_fetch();
        push(S_FETCH1, 1'b0);
        push_mem(S_FETCH2);
        push(S_FETCH3, 1'b0);
        push(S_DECODE, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Called on the cycle the DUT is in FETCH1; returns at the next FETCH1.
    task automatic instr(input logic [15:0] ir, input logic ben);
        IR = ir;
        BEN = ben;
        pushed = 0;
        push_fetch();
        case (ir[15:12])
            4'b0001: push(S_ADD, 1'b0);
            4'b0101: push(S_AND, 1'b0);
            4'b1001: push(S_NOT, 1'b0);
            4'b0000: begin
                push(S_BR0, 1'b0);
                if (ben) push(S_BR1, 1'b0);
            end
            4'b1100: push(S_JMP, 1'b0);
            4'b0110: begin
                push(S_LDR1, 1'b0);
                push_mem(S_LDR2);
                push(S_LDR3, 1'b0);
            end
            4'b0111: begin
                push(S_STR1, 1'b0);
                push(S_STR2, 1'b0);
                push_mem(S_STR3);
            end
            default: ;
        endcase
        step(pushed);
    endtask

    // Monitor: compare one expected record per cycle while any are queued.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            mon_rec = sb.pop_front();
            checks++;
            if ({state_dbg, act_ctl} !== {mon_rec.st, mon_rec.ctl}) begin
                errors++;
                $display("FAIL trace t=%0t state act=%0d exp=%0d ctl act=%05h exp=%05h",
                         $time, state_dbg, mon_rec.st, act_ctl, mon_rec.ctl);
            end
        end
    end

    initial begin
        Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; IR = 16'h0000; BEN = 1'b0;
        step(2);
        Reset_n = 1'b1;
        repeat (10) push(S_HALT, 1'b0);
        step(10);

        Run = 1'b1;
        push(S_HALT, 1'b0);
        step(1);
        Run = 1'b0;

        instr(16'h1042, 1'b0);
        instr(16'h5042, 1'b0);
        instr(16'h907F, 1'b0);
        instr(16'h0E05, 1'b1);
        instr(16'h0E05, 1'b0);
        instr(16'hC1C0, 1'b0);
        instr(16'h6283, 1'b0);
        instr(16'h7283, 1'b0);
        instr(16'h2000, 1'b0);

`ifdef LC3_PAUSE_EN
        IR = 16'hD000;
        Continue = 1'b0;
        pushed = 0;
        push_fetch();
        repeat (4) push(S_PAUSE, 1'b0);
        step(9);
        Continue = 1'b1;
        step(1);
        Continue = 1'b0;
`else
        Continue = 1'b1;
        instr(16'hD000, 1'b0);
        Continue = 1'b0;
`endif

        // Store interrupted by reset in its second write cycle, Run held high.
        IR = 16'h7283;
        pushed = 0;
        push_fetch();
        push(S_STR1, 1'b0);
        push(S_STR2, 1'b0);
        push(S_STR3, 1'b0);
        push(S_STR3, 1'b0);
        step(9);
        Reset_n = 1'b0;
        Run = 1'b1;
        push(S_HALT, 1'b0);
        push(S_HALT, 1'b0);
        step(2);
        Reset_n = 1'b1;
        step(1);
        Run = 1'b0;

        instr(16'h1042, 1'b0);
        instr(16'h6283, 1'b0);

        @(negedge Clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain queue left=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
